// File: rtl/cadr_clk_pkg.sv
// Shared state encoding and default tick constants for the CADR machine-cycle clock generator.
package cadr_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } clk_state_e;

  localparam int CNT_W           = 6;
  localparam int TAP_WIDTH       = 5;
  localparam int DEF_SHORT_TICKS = 16;
  localparam int DEF_LONG_TICKS  = 24;
  localparam int DEF_HIGH_TICKS  = 6;
  localparam int DEF_WP_START    = 10;
  localparam int DEF_WP_LEN      = 4;

  function automatic logic [CNT_W-1:0] to_cnt(input int v);
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/clk_tap_line.sv
// Clocked replacement for the analog delay line: tap k carries din delayed k+1 ticks.
module clk_tap_line #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic [WIDTH-1:0] taps
);

  always_ff @(posedge clk) begin
    if (reset) taps <= '0;
    else       taps <= {taps[WIDTH-2:0], din};
  end

endmodule

// File: rtl/cadr_clock_gen.sv
// Machine-cycle clock generator: free-run or single-step cycles of short/long length,
// producing the tpclk phase, tpwp write pulse, delay-line taps and a completed-cycle counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no cycle in progress, cnt held at 0, pulses low
// ST_RUN  | free-running; next cycle starts back-to-back while run=1
// ST_STEP | single stepped cycle; step_ack after it unless run rose
module cadr_clock_gen
  import cadr_clk_pkg::*;
#(
  parameter int          SHORT_TICKS    = DEF_SHORT_TICKS,
  parameter int          LONG_TICKS     = DEF_LONG_TICKS,
  parameter int          HIGH_TICKS     = DEF_HIGH_TICKS,
  parameter int          WP_START       = DEF_WP_START,
  parameter int          WP_LEN         = DEF_WP_LEN,
  parameter logic [15:0] CYC_COUNT_INIT = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step_req,
  input  logic                 long_cycle,
  output logic                 step_ack,
  output logic                 tpclk,
  output logic                 tpwp,
  output logic [TAP_WIDTH-1:0] taps,
  output logic                 cyc_start,
  output logic                 busy,
  output logic [15:0]          cyc_count
);

  if (!(HIGH_TICKS > 0 && HIGH_TICKS < SHORT_TICKS && SHORT_TICKS <= LONG_TICKS &&
        LONG_TICKS <= 63 && WP_START >= 0 && WP_LEN > 0 &&
        WP_START + WP_LEN <= SHORT_TICKS)) begin : g_param_check
    $error("cadr_clock_gen: illegal tick parameters");
  end

  localparam logic [CNT_W-1:0] SHORT_C    = to_cnt(SHORT_TICKS);
  localparam logic [CNT_W-1:0] LONG_C     = to_cnt(LONG_TICKS);
  localparam logic [CNT_W-1:0] HIGH_C     = to_cnt(HIGH_TICKS);
  localparam logic [CNT_W-1:0] WP_START_C = to_cnt(WP_START);
  localparam logic [CNT_W-1:0] WP_END_C   = to_cnt(WP_START + WP_LEN);

  clk_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] period, period_n;
  logic             start, cycle_end, ack_n, busy_n;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    period_n  = period;
    start     = 1'b0;
    ack_n     = 1'b0;
    cycle_end = (state != ST_IDLE) && (cnt == period - 6'd1);
    case (state)
      ST_IDLE: begin
        if (run) begin
          state_n = ST_RUN;
          start   = 1'b1;
        end else if (step_req) begin
          state_n = ST_STEP;
          start   = 1'b1;
        end
      end
      ST_RUN, ST_STEP: begin
        if (cycle_end) begin
          if (run) begin
            state_n = ST_RUN;
            start   = 1'b1;
          end else begin
            state_n = ST_IDLE;
            ack_n   = (state == ST_STEP);
          end
        end else begin
          cnt_n = cnt + 6'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Cycle length is frozen at the start edge; later long_cycle changes wait for the next cycle.
    if (start) begin
      cnt_n    = '0;
      period_n = long_cycle ? LONG_C : SHORT_C;
    end else if (state_n == ST_IDLE) begin
      cnt_n = '0;
    end
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      period    <= SHORT_C;
      tpclk     <= 1'b0;
      tpwp      <= 1'b0;
      cyc_start <= 1'b0;
      step_ack  <= 1'b0;
      cyc_count <= CYC_COUNT_INIT;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      period    <= period_n;
      tpclk     <= busy_n && (cnt_n < HIGH_C);
      tpwp      <= busy_n && (cnt_n >= WP_START_C) && (cnt_n < WP_END_C);
      cyc_start <= start;
      step_ack  <= ack_n;
      if (cycle_end) cyc_count <= cyc_count + 16'd1;
    end
  end

  assign busy = (state != ST_IDLE);

  clk_tap_line #(.WIDTH(TAP_WIDTH)) u_taps (
    .clk   (clk),
    .reset (reset),
    .din   (tpclk),
    .taps  (taps)
  );

endmodule

// File: tb/tb_cadr_clock_gen.sv
// Bench for cadr_clock_gen: cycle-level reference model compared every tick, plus literal pins.
module tb_cadr_clock_gen;

  localparam int SHORT = 16;
  localparam int LONG  = 24;
  localparam int HIGH  = 6;
  localparam int WPS   = 10;
  localparam int WPL   = 4;

  logic clk = 1'b0, reset = 1'b1, run = 1'b0, step_req = 1'b0, long_cycle = 1'b0, run2 = 1'b0;
  logic step_ack, tpclk, tpwp, cyc_start, busy;
  logic [4:0] taps;
  logic [15:0] cyc_count;
  logic ack2, tp2, wp2, cs2, busy2;
  logic [4:0] taps2;
  logic [15:0] count2;
  int checks = 0, failures = 0;
  logic [15:0] acks;

  always #5 clk = ~clk;

  cadr_clock_gen dut (
    .clk(clk), .reset(reset), .run(run), .step_req(step_req), .long_cycle(long_cycle),
    .step_ack(step_ack), .tpclk(tpclk), .tpwp(tpwp), .taps(taps),
    .cyc_start(cyc_start), .busy(busy), .cyc_count(cyc_count)
  );

  cadr_clock_gen #(.CYC_COUNT_INIT(16'hFFFE)) dut_wrap (
    .clk(clk), .reset(reset), .run(run2), .step_req(1'b0), .long_cycle(1'b0),
    .step_ack(ack2), .tpclk(tp2), .tpwp(wp2), .taps(taps2),
    .cyc_start(cs2), .busy(busy2), .cyc_count(count2)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the current machine cycle and its frozen length.
  bit          m_ready = 1'b0, m_active = 1'b0, m_is_step = 1'b0;
  int          m_pos = 0, m_len = SHORT;
  bit          m_tpclk = 1'b0, m_tpwp = 1'b0, m_cs = 1'b0, m_ack = 1'b0;
  logic [4:0]  m_taps = '0;
  logic [15:0] m_count = '0;

  task automatic m_begin(input bit is_step);
    m_active  = 1'b1;
    m_is_step = is_step;
    m_pos     = 0;
    m_len     = long_cycle ? LONG : SHORT;
    m_cs      = 1'b1;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0; m_pos = 0; m_tpclk = 1'b0; m_tpwp = 1'b0;
      m_cs = 1'b0; m_ack = 1'b0; m_taps = '0; m_count = '0;
    end else begin
      m_taps = {m_taps[3:0], m_tpclk};
      m_cs   = 1'b0;
      m_ack  = 1'b0;
      if (m_active && m_pos == m_len - 1) begin
        m_count = m_count + 16'd1;
        if (run) m_begin(1'b0);
        else begin
          m_ack    = m_is_step;
          m_active = 1'b0;
        end
      end else if (m_active) begin
        m_pos++;
      end else if (run) begin
        m_begin(1'b0);
      end else if (step_req) begin
        m_begin(1'b1);
      end
      m_tpclk = m_active && (m_pos < HIGH);
      m_tpwp  = m_active && (m_pos >= WPS) && (m_pos < WPS + WPL);
    end
    m_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk1("tpclk", tpclk, m_tpclk);
      chk1("tpwp", tpwp, m_tpwp);
      chk1("cyc_start", cyc_start, m_cs);
      chk1("busy", busy, m_active);
      chk1("step_ack", step_ack, m_ack);
      chk16("taps", {11'd0, taps}, {11'd0, m_taps});
      chk16("cyc_count", cyc_count, m_count);
    end
  end

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk16("rst_count", cyc_count, 16'h0000);
    chk16("rst_wrap_count", count2, 16'hFFFE);
    reset = 1'b0;

    // Free run, long cycle selected mid-cycle, run dropped mid-cycle.
    @(negedge clk); run = 1'b1;
    for (int t = 0; t <= 104; t++) begin
      @(negedge clk);
      case (t)
        0:   begin chk1("run_cs0", cyc_start, 1'b1); chk1("run_tp0", tpclk, 1'b1); end
        4:   chk1("run_tap4_off", taps[4], 1'b0);
        5:   begin chk1("run_tp5", tpclk, 1'b1); chk1("run_tap4_on", taps[4], 1'b1); end
        6:   chk1("run_tp6", tpclk, 1'b0);
        9:   chk1("run_wp9", tpwp, 1'b0);
        10:  chk1("run_wp10", tpwp, 1'b1);
        13:  chk1("run_wp13", tpwp, 1'b1);
        14:  chk1("run_wp14", tpwp, 1'b0);
        15:  chk1("run_cs15", cyc_start, 1'b0);
        16:  chk1("run_cs16", cyc_start, 1'b1);
        51:  long_cycle = 1'b1;
        64:  chk1("long_cs64", cyc_start, 1'b1);
        67:  long_cycle = 1'b0;
        80:  chk1("long_cs80", cyc_start, 1'b0);
        88:  chk1("long_cs88", cyc_start, 1'b1);
        93:  run = 1'b0;
        103: chk1("drop_busy103", busy, 1'b1);
        104: begin chk1("drop_busy104", busy, 1'b0); chk16("drop_count", cyc_count, 16'd6); end
        default: ;
      endcase
    end

    // Single step; a second request while busy must be dropped.
    pulse_reset();
    @(negedge clk); step_req = 1'b1;
    for (int u = 0; u <= 17; u++) begin
      @(negedge clk);
      case (u)
        0:  begin chk1("step_cs0", cyc_start, 1'b1); step_req = 1'b0; end
        8:  step_req = 1'b1;
        9:  step_req = 1'b0;
        15: begin chk1("step_ack15", step_ack, 1'b0); chk16("step_count15", cyc_count, 16'd0); end
        16: begin
          chk1("step_ack16", step_ack, 1'b1);
          chk1("step_busy16", busy, 1'b0);
          chk16("step_count16", cyc_count, 16'd1);
        end
        17: begin chk1("step_ack17", step_ack, 1'b0); chk1("step_busy17", busy, 1'b0); end
        default: ;
      endcase
    end

    // run and step_req together: RUN wins, no ack.
    acks = '0;
    @(negedge clk); run = 1'b1; step_req = 1'b1;
    for (int u = 0; u <= 20; u++) begin
      @(negedge clk);
      acks = acks + {15'd0, step_ack};
      case (u)
        0:  step_req = 1'b0;
        5:  run = 1'b0;
        15: chk1("both_busy15", busy, 1'b1);
        16: chk1("both_busy16", busy, 1'b0);
        default: ;
      endcase
    end
    chk16("both_no_ack", acks, 16'd0);

    // run rising during a stepped cycle converts it to RUN.
    @(negedge clk); step_req = 1'b1;
    for (int u = 0; u <= 32; u++) begin
      @(negedge clk);
      case (u)
        0:  step_req = 1'b0;
        4:  run = 1'b1;
        16: begin
          chk1("conv_cs16", cyc_start, 1'b1);
          chk1("conv_ack16", step_ack, 1'b0);
          chk1("conv_busy16", busy, 1'b1);
          run = 1'b0;
        end
        32: begin
          chk1("conv_busy32", busy, 1'b0);
          chk1("conv_ack32", step_ack, 1'b0);
          chk16("conv_count32", cyc_count, 16'd4);
        end
        default: ;
      endcase
    end

    // Reset in the middle of a running cycle.
    @(negedge clk); run = 1'b1;
    for (int u = 0; u <= 14; u++) begin
      @(negedge clk);
      case (u)
        8: begin
          chk16("rstmid_taps_pre", {11'd0, taps}, 16'h001C);
          reset = 1'b1; run = 1'b0;
        end
        9: begin
          chk1("rstmid_busy", busy, 1'b0);
          chk1("rstmid_tpclk", tpclk, 1'b0);
          chk16("rstmid_taps", {11'd0, taps}, 16'h0000);
          chk16("rstmid_count", cyc_count, 16'h0000);
          reset = 1'b0;
        end
        14: begin chk1("rstmid_idle_busy", busy, 1'b0); chk1("rstmid_idle_tp", tpclk, 1'b0); end
        default: ;
      endcase
    end

    // Counter wrap on the preloaded instance.
    chk16("wrap_pre", count2, 16'hFFFE);
    @(negedge clk); run2 = 1'b1;
    for (int w = 0; w <= 32; w++) begin
      @(negedge clk);
      case (w)
        0:  chk1("wrap_cs0", cs2, 1'b1);
        15: chk16("wrap_count15", count2, 16'hFFFE);
        16: chk16("wrap_count16", count2, 16'hFFFF);
        32: begin chk16("wrap_count32", count2, 16'h0000); run2 = 1'b0; end
        default: ;
      endcase
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
